aes_128_dec: RTL and testbench



---
 rtl/aes_128_dec.sv | 271 +++++++++++++++++++++++++++
 tb/tb_aes_128_dec.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_dec.sv
// rtl/aes_128_dec.sv - iterative AES-128 decryption core; optional K10 key cache under AES_DEC_KEY_CACHE_EN

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, computed as a^254 (0 maps to 0)
module gf_inv8 (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] acc;

    // a^254 = a^2 * a^4 * ... * a^128
    always_comb begin
        sq  = a_i;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        y_o = acc;
    end
endmodule

// Forward S-box: inverse followed by the affine map
module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] inv;

    gf_inv8 u_inv (.a_i(a_i), .y_o(inv));

    assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine map followed by the field inverse
module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] aff;

    assign aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;

    gf_inv8 u_inv (.a_i(aff), .y_o(y_o));
endmodule

module aes_128_dec (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);
    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] ct_r_q, ct_r_d;
    logic [127:0] k_q, k_d;
    logic [127:0] s_q, s_d;
    logic [127:0] pt_q, pt_d;
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_tag_q, key_tag_d;
    logic [127:0] k10_cache_q, k10_cache_d;
    logic         cache_vld_q, cache_vld_d;
`endif

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            y[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            y[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            y[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return y;
    endfunction

    // Key path: the four S-boxes are shared between forward expansion (on w3)
    // and inverse expansion (on the recovered w3' = w3 ^ w2).
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, rot, sub_out, temp;
    logic [127:0] k_fwd, k_inv;

    assign {w0, w1, w2, w3} = k_q;
    assign sub_in = (state_q == ROUND) ? (w3 ^ w2) : w3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        sbox u_sbox (.a_i(rot[8*g +: 8]), .y_o(sub_out[8*g +: 8]));
    end

    assign temp = sub_out ^ {rcon(cnt_q), 24'h0};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0    = w0 ^ temp;
        f1    = w1 ^ f0;
        f2    = w2 ^ f1;
        f3    = w3 ^ f2;
        k_fwd = {f0, f1, f2, f3};
        k_inv = {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    // Data path: InvShiftRows is pure wiring, then 16 inverse S-boxes
    logic [127:0] isr, isb, t, imc;

    for (genvar i = 0; i < 16; i++) begin : g_bytes
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = 4 * ((C - R + 4) % 4) + R;
        assign isr[127-8*i -: 8] = s_q[127-8*SRC -: 8];
        inv_sbox u_inv_sbox (.a_i(isr[127-8*i -: 8]), .y_o(isb[127-8*i -: 8]));
    end

    assign t   = isb ^ k_inv;
    assign imc = inv_mix(t);

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign pt        = pt_q;

    // Next-state and datapath register updates for the round-iterative FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ct_r_d  = ct_r_q;
        k_d     = k_q;
        s_d     = s_q;
        pt_d    = pt_q;
`ifdef AES_DEC_KEY_CACHE_EN
        key_tag_d   = key_tag_q;
        k10_cache_d = k10_cache_q;
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld_q && (key == key_tag_q)) begin
                        k_d     = k10_cache_q;
                        s_d     = ct ^ k10_cache_q;
                        cnt_d   = 4'd9;
                        state_d = ROUND;
                    end else begin
                        ct_r_d      = ct;
                        k_d         = key;
                        cnt_d       = 4'd0;
                        key_tag_d   = key;
                        cache_vld_d = 1'b0;
                        state_d     = KEYEXP;
                    end
`else
                    ct_r_d  = ct;
                    k_d     = key;
                    cnt_d   = 4'd0;
                    state_d = KEYEXP;
`endif
                end
            end
            KEYEXP: begin
                k_d = k_fwd;
                if (cnt_q == 4'd9) begin
                    s_d     = ct_r_q ^ k_fwd;
                    cnt_d   = 4'd9;
                    state_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    k10_cache_d = k_fwd;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                if (cnt_q == 4'd0) begin
                    pt_d    = t;
                    state_d = DONE;
                end else begin
                    s_d   = imc;
                    k_d   = k_inv;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any block in flight and drops the cache
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ct_r_q  <= '0;
            k_q     <= '0;
            s_q     <= '0;
            pt_q    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            key_tag_q   <= '0;
            k10_cache_q <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ct_r_q  <= ct_r_d;
            k_q     <= k_d;
            s_q     <= s_d;
            pt_q    <= pt_d;
`ifdef AES_DEC_KEY_CACHE_EN
            key_tag_q   <= key_tag_d;
            k10_cache_q <= k10_cache_d;
            cache_vld_q <= cache_vld_d;
`endif
        end
    end
endmodule

// File: tb/tb_aes_128_dec.sv
// tb/tb_aes_128_dec.sv - scoreboard bench for aes_128_dec
module tb_aes_128_dec;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    aes_128_dec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready), .pt(pt)
    );

    always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int LAT_HIT = 10;
`else
    localparam int LAT_HIT = 20;
`endif
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [7:0] sbox_t [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference AES-128 encryption used to build loopback ciphertexts
    function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, t, rk;
        logic [31:0]  w0, w1, w2, w3, tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        rc = 8'h01;
        s  = p ^ k;
        rk = k;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end
            {w0, w1, w2, w3} = rk;
            tmp = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
            w0 = w0 ^ tmp;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rk = {w0, w1, w2, w3};
            rc = xt(rc);
            s  = t ^ rk;
        end
        return s;
    endfunction

    task automatic build_sbox();
        logic [7:0] p8, q8, x8;
        p8 = 8'h01;
        q8 = 8'h01;
        do begin
            p8 = p8 ^ {p8[6:0], 1'b0} ^ (p8[7] ? 8'h1b : 8'h00);
            q8 = q8 ^ {q8[6:0], 1'b0};
            q8 = q8 ^ {q8[5:0], 2'b0};
            q8 = q8 ^ {q8[3:0], 4'b0};
            if (q8[7]) q8 = q8 ^ 8'h09;
            x8 = q8 ^ {q8[6:0], q8[7]} ^ {q8[5:0], q8[7:6]} ^ {q8[4:0], q8[7:5]} ^ {q8[3:0], q8[7:4]};
            sbox_t[p8] = x8 ^ 8'h63;
        end while (p8 != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer a block and hold it until accepted; record expected result and due cycle
    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] exp,
                        input int lat, input bit expect_out);
        int guard;
        exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        ct       = c;
        key      = k;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            check("accept_timeout", 128'(in_ready), 128'(1));
        end else if (expect_out) begin
            e.pt  = exp;
            e.due = cyc + 1 + lat;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        ct       = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_timeout", 128'(sb.size()), 128'(0));
    endtask

    // Monitor: compares every presented result against the scoreboard head
    initial begin
        bit took;
        bit ov_prev;
        took    = 1'b0;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (took) check("idle_after_take", {126'b0, in_ready, out_valid}, 128'h2);
                took = 1'b0;
                if (sb.size() == 0) begin
                    check("no_spurious_out_valid", 128'(out_valid), 128'(0));
                end else if (out_valid) begin
                    if (!ov_prev) check("latency", 128'(cyc), 128'(sb[0].due));
                    check("pt", pt, sb[0].pt);
                    check("in_ready_low_in_done", 128'(in_ready), 128'(0));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        took = 1'b1;
                    end
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rp;
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ct        = '0;
        key       = '0;
        build_sbox();
        check("model_c1", enc(C1_PT, C1_KEY), C1_CT);

        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_pt", pt, 128'(0));
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 128'(in_ready), 128'(1));

        // C.1 with backpressure
        out_ready = 1'b0;
        send(C1_CT, C1_KEY, C1_PT, 20, 1'b1);
        guard = 0;
        while (!out_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("bp_out_valid_rise", 128'(out_valid), 128'(1));
        repeat (50) begin
            tick();
            check("bp_pt_stable", pt, C1_PT);
            check("bp_out_valid_held", 128'(out_valid), 128'(1));
            check("bp_in_ready_low", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;

        // Same key again (cache hit when enabled), then App. B key, back to back
        send(C1_CT, C1_KEY, C1_PT, LAT_HIT, 1'b1);
        send(B_CT, B_KEY, B_PT, 20, 1'b1);
        send(B_CT, B_KEY, B_PT, LAT_HIT, 1'b1);
        drain();

        // Reset at KEYEXP cycle 7 discards the block
        send(C1_CT, C1_KEY, C1_PT, 20, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        tick();
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        rst = 1'b0;
        #1;
        check("mid_rst_idle", 128'(in_ready), 128'(1));
        repeat (30) tick();
        send(C1_CT, C1_KEY, C1_PT, 20, 1'b1);

        // Loopback of random pairs through the reference encryption
        for (int n = 0; n < 200; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            send(enc(rp, rk), rk, rp, 20, 1'b1);
        end
        drain();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
